// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master-side bus monitor.
// Holds the protocol FSM encoding, SDA-direction encodings and byte size.
// No logic; imported by the monitor top.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    ACK  = 2'd2,
    DATA = 2'd3
  } i2c_state_e;

  localparam logic SDA_DIR_MASTER = 1'b0;
  localparam logic SDA_DIR_SLAVE  = 1'b1;

  localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_bus_monitor_if.sv
// Bundle of raw master-side pins and the decoded monitor outputs.
// Ports: scl_in/sda_in (raw pins) plus filtered lines, condition pulses,
// bit/byte/ack reports and the registered SDA-direction hint.
// slave modport = monitor side, master modport = pin driver / consumer side.
interface i2c_bus_monitor_if;
  logic       scl_in;
  logic       sda_in;
  logic       scl_f;
  logic       sda_f;
  logic       start_pulse;
  logic       rstart_pulse;
  logic       stop_pulse;
  logic       busy;
  logic       bit_valid;
  logic       bit_data;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       addr_byte;
  logic       rw;
  logic       ack_valid;
  logic       ack;
  logic       sda_dir;

  modport master (
    output scl_in, sda_in,
    input  scl_f, sda_f, start_pulse, rstart_pulse, stop_pulse, busy,
           bit_valid, bit_data, byte_valid, byte_data, addr_byte, rw,
           ack_valid, ack, sda_dir
  );

  modport slave (
    input  scl_in, sda_in,
    output scl_f, sda_f, start_pulse, rstart_pulse, stop_pulse, busy,
           bit_valid, bit_data, byte_valid, byte_data, addr_byte, rw,
           ack_valid, ack, sda_dir
  );
endinterface

// File: rtl/i2c_glitch_filter.sv
// Purpose: 2-FF synchronizer plus optional stability filter for one I2C line.
// Latency: 2 + FILT_LEN clk with I2C_MON_GLITCH_FILTER_EN defined, else 2 clk.
// Backpressure: none. Ports: clk, rst (async active-low), raw_in, filt_out.
module i2c_glitch_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic filt_out
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
  end

  // Idle I2C lines are high, so the synchronizer resets to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef I2C_MON_GLITCH_FILTER_EN
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;

  // Counter measures how long the synced value has disagreed with the
  // filtered one; any agreement restarts it, so short glitches never pass.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = 4'd0;
    if (sync2_q != filt_q) begin
      if (cnt_q == 4'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= 1'b1;
      cnt_q  <= 4'd0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_out = filt_q;
`else
  assign filt_out = sync2_q;

  // FILT_LEN has no effect without the filter stage.
  logic unused_filt_len;
  assign unused_filt_len = (FILT_LEN == 0);
`endif

endmodule

// File: rtl/i2c_bus_monitor.sv
// Purpose: master-side I2C monitor: filters SCL/SDA, detects START/rSTART/STOP,
//   assembles bits/bytes/ACK, registers an SDA-direction hint for the forwarder.
// Latency: pin -> pulse 3 + FILT_LEN clk (3 clk without I2C_MON_GLITCH_FILTER_EN).
// Backpressure: none; every report is a 1-cycle pulse that must be sampled.
// Ports: clk, rst (async active-low), bus (i2c_bus_monitor_if.slave).
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic               clk,
  input  logic               rst,
  i2c_bus_monitor_if.slave   bus
);

  logic scl_f, sda_f;

  i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .raw_in(bus.scl_in), .filt_out(scl_f)
  );
  i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .raw_in(bus.sda_in), .filt_out(sda_f)
  );

  logic scl_p_q, scl_p_d, sda_p_q, sda_p_d;
  logic scl_rise, scl_fall, start_cond, stop_cond;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shreg_q, shreg_d;
  logic       ack_slot_q, ack_slot_d;   // ACK bit sampled, its falling edge pending
  logic       start_pulse_q, start_pulse_d, rstart_pulse_q, rstart_pulse_d;
  logic       stop_pulse_q, stop_pulse_d, busy_q, busy_d;
  logic       bit_valid_q, bit_valid_d, bit_data_q, bit_data_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       addr_byte_q, addr_byte_d, rw_q, rw_d;
  logic       ack_valid_q, ack_valid_d, ack_q, ack_d, sda_dir_q, sda_dir_d;

  assign scl_p_d  = scl_f;
  assign sda_p_d  = sda_f;
  assign scl_rise = scl_f & ~scl_p_q;
  assign scl_fall = ~scl_f & scl_p_q;
  // Requiring SCL high in both cycles means a simultaneous SCL/SDA change is
  // treated purely as an SCL edge.
  assign start_cond = scl_f & scl_p_q & sda_p_q & ~sda_f;
  assign stop_cond  = scl_f & scl_p_q & ~sda_p_q & sda_f;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (stop_cond) begin
      state_d = IDLE;
    end else if (start_cond) begin
      state_d = ADDR;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, DATA: if (bit_cnt_q == 4'(BITS_PER_BYTE - 1)) state_d = ACK;
        ACK:        state_d = DATA;
        default:    state_d = state_q;
      endcase
    end
  end

  // FSM outputs and datapath next values
  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    ack_slot_d     = ack_slot_q;
    start_pulse_d  = 1'b0;
    rstart_pulse_d = 1'b0;
    stop_pulse_d   = 1'b0;
    bit_valid_d    = 1'b0;
    byte_valid_d   = 1'b0;
    ack_valid_d    = 1'b0;
    busy_d         = busy_q;
    bit_data_d     = bit_data_q;
    byte_data_d    = byte_data_q;
    addr_byte_d    = addr_byte_q;
    rw_d           = rw_q;
    ack_d          = ack_q;
    sda_dir_d      = sda_dir_q;

    if (stop_cond) begin
      // Any partial byte is dropped; byte_data keeps the last complete byte.
      stop_pulse_d = 1'b1;
      busy_d       = 1'b0;
      bit_cnt_d    = 4'd0;
      shreg_d      = 7'd0;
      ack_slot_d   = 1'b0;
      sda_dir_d    = SDA_DIR_MASTER;
    end else if (start_cond) begin
      start_pulse_d  = (state_q == IDLE);
      rstart_pulse_d = (state_q != IDLE);
      busy_d         = 1'b1;
      bit_cnt_d      = 4'd0;
      shreg_d        = 7'd0;
      ack_slot_d     = 1'b0;
      sda_dir_d      = SDA_DIR_MASTER;
    end else if (state_q != IDLE) begin
      if (scl_rise) begin
        bit_valid_d = 1'b1;
        bit_data_d  = sda_f;
        if (state_q == ACK) begin
          ack_valid_d = 1'b1;
          ack_d       = sda_f;
          bit_cnt_d   = 4'd0;
          ack_slot_d  = 1'b1;
        end else begin
          shreg_d   = {shreg_q[5:0], sda_f};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(BITS_PER_BYTE - 1)) begin
            byte_valid_d = 1'b1;
            byte_data_d  = {shreg_q, sda_f};
            addr_byte_d  = (state_q == ADDR);
            if (state_q == ADDR) rw_d = sda_f;
          end
        end
      end else if (scl_fall) begin
        if (state_q == ACK) begin
          // End of the 8th bit: the receiver of this byte drives the ACK.
          sda_dir_d = (addr_byte_q || !rw_q) ? SDA_DIR_SLAVE : SDA_DIR_MASTER;
        end else if (ack_slot_q) begin
          // End of the ACK slot: slave keeps SDA only for an acked read.
          sda_dir_d  = (rw_q && !ack_q) ? SDA_DIR_SLAVE : SDA_DIR_MASTER;
          ack_slot_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_p_q        <= 1'b1;
      sda_p_q        <= 1'b1;
      bit_cnt_q      <= 4'd0;
      shreg_q        <= 7'd0;
      ack_slot_q     <= 1'b0;
      start_pulse_q  <= 1'b0;
      rstart_pulse_q <= 1'b0;
      stop_pulse_q   <= 1'b0;
      busy_q         <= 1'b0;
      bit_valid_q    <= 1'b0;
      bit_data_q     <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'h00;
      addr_byte_q    <= 1'b0;
      rw_q           <= 1'b0;
      ack_valid_q    <= 1'b0;
      ack_q          <= 1'b1;
      sda_dir_q      <= SDA_DIR_MASTER;
    end else begin
      scl_p_q        <= scl_p_d;
      sda_p_q        <= sda_p_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      ack_slot_q     <= ack_slot_d;
      start_pulse_q  <= start_pulse_d;
      rstart_pulse_q <= rstart_pulse_d;
      stop_pulse_q   <= stop_pulse_d;
      busy_q         <= busy_d;
      bit_valid_q    <= bit_valid_d;
      bit_data_q     <= bit_data_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      addr_byte_q    <= addr_byte_d;
      rw_q           <= rw_d;
      ack_valid_q    <= ack_valid_d;
      ack_q          <= ack_d;
      sda_dir_q      <= sda_dir_d;
    end
  end

  assign bus.scl_f        = scl_f;
  assign bus.sda_f        = sda_f;
  assign bus.start_pulse  = start_pulse_q;
  assign bus.rstart_pulse = rstart_pulse_q;
  assign bus.stop_pulse   = stop_pulse_q;
  assign bus.busy         = busy_q;
  assign bus.bit_valid    = bit_valid_q;
  assign bus.bit_data     = bit_data_q;
  assign bus.byte_valid   = byte_valid_q;
  assign bus.byte_data    = byte_data_q;
  assign bus.addr_byte    = addr_byte_q;
  assign bus.rw           = rw_q;
  assign bus.ack_valid    = ack_valid_q;
  assign bus.ack          = ack_q;
  assign bus.sda_dir      = sda_dir_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Self-checking bench for i2c_bus_monitor: drives master SCL/SDA waveforms,
// pushes expected bytes/ACKs to scoreboard queues and checks them as reported.
// Works with or without I2C_MON_GLITCH_FILTER_EN defined.
module tb_i2c_bus_monitor;
  localparam int FILT_LEN = 3;
  localparam int H = 10;  // SCL half period in clk cycles

`ifdef I2C_MON_GLITCH_FILTER_EN
  localparam int   GL_STARTS = 0;
  localparam logic GL_LOW    = 1'b0;
`else
  localparam int   GL_STARTS = 1;
  localparam logic GL_LOW    = 1'b1;
`endif

  // {scl_f, sda_f, start, rstart, stop, busy, bit_valid, bit_data, byte_valid,
  //  byte_data, addr_byte, rw, ack_valid, ack, sda_dir}
  localparam logic [21:0] RST_VEC = {1'b1, 1'b1, 7'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_bus_monitor_if bus();

  i2c_bus_monitor #(.FILT_LEN(FILT_LEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [21:0] out_vec;
  assign out_vec = {bus.scl_f, bus.sda_f, bus.start_pulse, bus.rstart_pulse, bus.stop_pulse,
                    bus.busy, bus.bit_valid, bus.bit_data, bus.byte_valid, bus.byte_data,
                    bus.addr_byte, bus.rw, bus.ack_valid, bus.ack, bus.sda_dir};

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       addr;
    logic       rw;
  } exp_byte_t;

  exp_byte_t byte_q[$];
  logic      ack_q[$];
  exp_byte_t mon_e;
  logic      mon_a;
  int n_start = 0, n_rstart = 0, n_stop = 0, n_bit = 0, n_byte = 0, n_ack = 0;

  // Scoreboard side: pop and compare whenever the DUT reports a byte or ACK.
  always @(negedge clk) begin
    if (rst) begin
      n_start  += int'(bus.start_pulse);
      n_rstart += int'(bus.rstart_pulse);
      n_stop   += int'(bus.stop_pulse);
      n_bit    += int'(bus.bit_valid);
      if (bus.byte_valid) begin
        n_byte++;
        total++;
        if (byte_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte got=%h want=none", bus.byte_data);
        end else begin
          mon_e = byte_q.pop_front();
          if ({bus.byte_data, bus.addr_byte, bus.bit_valid} !== {mon_e.data, mon_e.addr, 1'b1}) begin
            bad++;
            $display("FAIL byte data/addr/bitvld got=%h/%b/%b want=%h/%b/1",
                     bus.byte_data, bus.addr_byte, bus.bit_valid, mon_e.data, mon_e.addr);
          end
          if (mon_e.addr) begin
            total++;
            if (bus.rw !== mon_e.rw) begin
              bad++;
              $display("FAIL rw got=%b want=%b", bus.rw, mon_e.rw);
            end
          end
        end
      end
      if (bus.ack_valid) begin
        n_ack++;
        total++;
        if (ack_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack got=%b want=none", bus.ack);
        end else begin
          mon_a = ack_q.pop_front();
          if ({bus.ack, bus.bit_valid} !== {mon_a, 1'b1}) begin
            bad++;
            $display("FAIL ack/bitvld got=%b/%b want=%b/1", bus.ack, bus.bit_valid, mon_a);
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    bus.sda_in = 1'b0; wait_clk(H);
    bus.scl_in = 1'b0; wait_clk(H/2);
  endtask

  task automatic send_rstart();
    bus.sda_in = 1'b1; wait_clk(H/2);
    bus.scl_in = 1'b1; wait_clk(H);
    bus.sda_in = 1'b0; wait_clk(H);
    bus.scl_in = 1'b0; wait_clk(H/2);
  endtask

  task automatic send_stop();
    bus.sda_in = 1'b0; wait_clk(H/2);
    bus.scl_in = 1'b1; wait_clk(H);
    bus.sda_in = 1'b1; wait_clk(H);
  endtask

  // One bit with SCL starting low; returns sda_dir seen mid SCL-high.
  task automatic send_bit(input logic b, output logic dir);
    bus.sda_in = b;    wait_clk(H/2);
    bus.scl_in = 1'b1; wait_clk(H/2);
    dir = bus.sda_dir; wait_clk(H/2);
    bus.scl_in = 1'b0; wait_clk(H/2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ackv, input logic is_addr,
                           input logic dir_b, input logic dir_a, input string name);
    logic d, bad_d;
    logic ok;
    ok = 1'b1;
    bad_d = dir_b;
    byte_q.push_back('{data: b, addr: is_addr, rw: b[0]});
    ack_q.push_back(ackv);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], d);
      if (d !== dir_b) begin ok = 1'b0; bad_d = d; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s byte_dir got=%b want=%b", name, bad_d, dir_b);
    end
    send_bit(ackv, d);
    total++;
    if (d !== dir_a) begin
      bad++;
      $display("FAIL %s ack_dir got=%b want=%b", name, d, dir_a);
    end
  endtask

  // SCL pulses with SDA changing only while SCL is low.
  task automatic idle_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.scl_in = 1'b0; wait_clk(H/2);
      bus.sda_in = i[0]; wait_clk(H/2);
      bus.scl_in = 1'b1; wait_clk(H);
    end
    bus.scl_in = 1'b0; wait_clk(H/2);
    bus.sda_in = 1'b1; wait_clk(H/2);
    bus.scl_in = 1'b1; wait_clk(2*H);
  endtask

  task automatic test_reset();
    bus.scl_in = 1'b1;
    bus.sda_in = 1'b1;
    rst = 1'b0;
    wait_clk(4);
    total++;
    if (out_vec !== RST_VEC) begin
      bad++;
      $display("FAIL reset_vec got=%h want=%h", out_vec, RST_VEC);
    end
    rst = 1'b1;
    wait_clk(2*H);
    total++;
    if (out_vec !== RST_VEC) begin
      bad++;
      $display("FAIL idle_vec got=%h want=%h", out_vec, RST_VEC);
    end
  endtask

  task automatic test_write();
    int s0, p0, b0, a0;
    s0 = n_start; p0 = n_stop; b0 = n_byte; a0 = n_ack;
    send_start();
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL w_busy got=%b want=1", bus.busy); end
    send_byte(8'hA0, 1'b0, 1'b1, 1'b0, 1'b1, "w_addr");
    send_byte(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, "w_data");
    send_stop();
    wait_clk(H);
    total++;
    if ({n_start - s0, n_stop - p0} !== {32'd1, 32'd1}) begin
      bad++;
      $display("FAIL w_start_stop got=%0d/%0d want=1/1", n_start - s0, n_stop - p0);
    end
    total++;
    if ({n_byte - b0, n_ack - a0} !== {32'd2, 32'd2}) begin
      bad++;
      $display("FAIL w_byte_ack_cnt got=%0d/%0d want=2/2", n_byte - b0, n_ack - a0);
    end
    total++;
    if ({bus.busy, bus.sda_dir, bus.ack} !== 3'b000) begin
      bad++;
      $display("FAIL w_end busy/dir/ack got=%b%b%b want=000", bus.busy, bus.sda_dir, bus.ack);
    end
  endtask

  task automatic test_read();
    int b0;
    b0 = n_byte;
    send_start();
    send_byte(8'hA1, 1'b0, 1'b1, 1'b0, 1'b1, "r_addr");
    send_byte(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, "r_data");
    send_stop();
    wait_clk(H);
    total++;
    if ({bus.rw, bus.byte_data, bus.ack, bus.addr_byte} !== {1'b1, 8'h5A, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL r_held rw/byte/ack/addr got=%b/%h/%b/%b want=1/5a/1/0",
               bus.rw, bus.byte_data, bus.ack, bus.addr_byte);
    end
    total++;
    if (n_byte - b0 != 2) begin
      bad++;
      $display("FAIL r_byte_cnt got=%0d want=2", n_byte - b0);
    end
  endtask

  task automatic test_glitch();
    int s0;
    logic seen_low;
    s0 = n_start;
    seen_low = 1'b0;
    bus.sda_in = 1'b0; wait_clk(2);
    bus.sda_in = 1'b1;
    for (int i = 0; i < 2*H; i++) begin
      wait_clk(1);
      if (bus.sda_f === 1'b0) seen_low = 1'b1;
    end
    total++;
    if (seen_low !== GL_LOW) begin
      bad++;
      $display("FAIL glitch_sda_low got=%b want=%b", seen_low, GL_LOW);
    end
    total++;
    if (n_start - s0 != GL_STARTS) begin
      bad++;
      $display("FAIL glitch_start got=%0d want=%0d", n_start - s0, GL_STARTS);
    end
    s0 = n_start;
    bus.sda_in = 1'b0; wait_clk(4);
    bus.sda_in = 1'b1; wait_clk(2*H);
    total++;
    if (n_start - s0 != 1) begin
      bad++;
      $display("FAIL held_low_start got=%0d want=1", n_start - s0);
    end
  endtask

  task automatic test_rstart();
    int s0, r0, p0;
    s0 = n_start; r0 = n_rstart; p0 = n_stop;
    send_start();
    send_byte(8'hA0, 1'b0, 1'b1, 1'b0, 1'b1, "rs_addr0");
    send_rstart();
    total++;
    if ({bus.busy, n_rstart - r0, n_start - s0, n_stop - p0} !== {1'b1, 32'd1, 32'd1, 32'd0}) begin
      bad++;
      $display("FAIL rstart busy/rst/st/sp got=%b/%0d/%0d/%0d want=1/1/1/0",
               bus.busy, n_rstart - r0, n_start - s0, n_stop - p0);
    end
    send_byte(8'hA1, 1'b0, 1'b1, 1'b0, 1'b1, "rs_addr1");
    send_stop();
    wait_clk(H);
    total++;
    if ({bus.busy, bus.sda_dir} !== 2'b00) begin
      bad++;
      $display("FAIL rs_end busy/dir got=%b%b want=00", bus.busy, bus.sda_dir);
    end
  endtask

  task automatic test_abort();
    int b0, p0, t0;
    logic d;
    logic [3:0] bits;
    bits = 4'b1011;
    send_start();
    send_byte(8'hA0, 1'b0, 1'b1, 1'b0, 1'b1, "ab_addr");
    b0 = n_byte; p0 = n_stop;
    for (int i = 3; i >= 0; i--) send_bit(bits[i], d);
    send_stop();
    wait_clk(H);
    total++;
    if ({n_byte - b0, n_stop - p0} !== {32'd0, 32'd1}) begin
      bad++;
      $display("FAIL abort byte/stop got=%0d/%0d want=0/1", n_byte - b0, n_stop - p0);
    end
    total++;
    if ({bus.busy, bus.sda_dir, bus.byte_data} !== {2'b00, 8'hA0}) begin
      bad++;
      $display("FAIL abort busy/dir/byte got=%b%b/%h want=00/a0", bus.busy, bus.sda_dir, bus.byte_data);
    end
    t0 = n_bit;
    idle_pulses(9);
    total++;
    if (n_bit - t0 != 0) begin
      bad++;
      $display("FAIL abort_idle_bits got=%0d want=0", n_bit - t0);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic d;
    send_start();
    send_byte(8'hA0, 1'b0, 1'b1, 1'b0, 1'b1, "rm_addr");
    send_bit(1'b0, d);
    send_bit(1'b1, d);
    send_bit(1'b1, d);
    rst = 1'b0;
    wait_clk(3);
    total++;
    if (out_vec !== RST_VEC) begin
      bad++;
      $display("FAIL midreset_vec got=%h want=%h", out_vec, RST_VEC);
    end
    bus.scl_in = 1'b1;
    bus.sda_in = 1'b1;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(H);
    t0 = n_bit;
    idle_pulses(9);
    total++;
    if ({n_bit - t0, 31'd0, bus.busy} !== 64'd0) begin
      bad++;
      $display("FAIL post_reset bits/busy got=%0d/%b want=0/0", n_bit - t0, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    wait_clk(2*H);
    test_read();
    wait_clk(2*H);
    test_glitch();
    wait_clk(2*H);
    test_rstart();
    wait_clk(2*H);
    test_abort();
    wait_clk(2*H);
    test_reset_mid();
    total++;
    if (byte_q.size() + ack_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left bytes=%0d acks=%0d want=0/0", byte_q.size(), ack_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
